// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-chip-select SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StTrail
  } spi_state_e;

  // Modes encoded as {cpol, cpha}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Divider for the ~400 kHz SD-card init rate from a 25 MHz clock.
  localparam int unsigned SD_INIT_DIV = 30;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: one-cycle tick every div_i+1 cycles while enabled.
module spi_clk_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Held at the reload value while disabled so the first enabled cycle starts a full period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == '0) begin
      cnt_d = div_i;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_master_mcs.sv
// Parametrised SPI master: all four modes, runtime divider, multiple chip selects.
// Defining SPI_LSB_FIRST_EN adds the lsb_first input for LSB-first transfers.
module spi_master_mcs
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NUM_CS = 1,
  parameter int unsigned DIV_W  = 8,
  localparam int unsigned CsW   = $clog2(NUM_CS) + 1
) (
  input  logic              clk25,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CsW-1:0]    cs_sel,
  input  logic              cs_hold,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);

  spi_state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic cpha_q, cpha_d, hold_q, hold_d, lsb_q, lsb_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic [EdgeW-1:0]  edge_q, edge_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic lsb_in, tick, sample;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_rx(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  spi_clk_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk_i (clk25),
    .rst_i (rst),
    .en_i  (state_q != StIdle),
    .div_i ((state_q == StIdle) ? clk_div : div_q),
    .tick_o(tick)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cpha_d  = cpha_q;
    hold_d  = hold_q;
    lsb_d   = lsb_q;
    div_d   = div_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    edge_d  = edge_q;
    cs_n_d  = cs_n_q;
    sample  = 1'b0;
    unique case (state_q)
      StIdle: begin
        sclk_d = cpol;
        // done_q blocks a start that coincides with the end-of-transfer pulse.
        if (start && !done_q) begin
          state_d = StSetup;
          busy_d  = 1'b1;
          cpha_d  = cpha;
          hold_d  = cs_hold;
          lsb_d   = lsb_in;
          div_d   = clk_div;
          edge_d  = '0;
          rx_sh_d = '0;
          tx_d    = tx_data;
          cs_n_d  = '1;
          for (int i = 0; i < int'(NUM_CS); i++) begin
            if (i == int'(cs_sel)) cs_n_d[i] = 1'b0;
          end
          if (!cpha) begin
            mosi_d = first_bit(tx_data, lsb_in);
            tx_d   = shift_tx(tx_data, lsb_in);
          end
        end
      end
      StSetup: begin
        if (tick) state_d = StShift;
      end
      StShift: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EdgeW'(1);
          // Even edge index is a leading edge; CPHA swaps which edge samples.
          sample = ~edge_q[0] ^ cpha_q;
          if (sample) begin
            rx_sh_d = shift_rx(rx_sh_q, spi_miso, lsb_q);
          end else if (edge_q != LastEdge) begin
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_tx(tx_q, lsb_q);
          end
          if (edge_q == LastEdge) state_d = StTrail;
        end
      end
      StTrail: begin
        if (tick) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          if (!hold_q) cs_n_d = '1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cpha_q  <= 1'b0;
      hold_q  <= 1'b0;
      lsb_q   <= 1'b0;
      div_q   <= '0;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      edge_q  <= '0;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cpha_q  <= cpha_d;
      hold_q  <= hold_d;
      lsb_q   <= lsb_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      edge_q  <= edge_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule
